// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the mini-CPU control unit.
//   - opcode values carried in IR[31:27] (also the ALU op codes on the datapath)
//   - sequencer state encoding
//   - instruction classes produced by instr_class_decode
//   - the control-strobe bundle driven by control_unit
package cpu_pkg;

    localparam int OPC_W = 5;
    localparam int IR_W  = 32;

    localparam logic [OPC_W-1:0] OP_LD   = 5'h00;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'h01;
    localparam logic [OPC_W-1:0] OP_ST   = 5'h02;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'h03;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'h04;
    localparam logic [OPC_W-1:0] OP_AND  = 5'h05;
    localparam logic [OPC_W-1:0] OP_OR   = 5'h06;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'h07;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'h08;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'h09;
    localparam logic [OPC_W-1:0] OP_SHRA = 5'h0A;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'h0B;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'h0C;
    localparam logic [OPC_W-1:0] OP_ANDI = 5'h0D;
    localparam logic [OPC_W-1:0] OP_ORI  = 5'h0E;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'h0F;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'h10;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'h11;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'h12;
    localparam logic [OPC_W-1:0] OP_MFLO = 5'h18;
    localparam logic [OPC_W-1:0] OP_MFHI = 5'h19;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'h1A;
    localparam logic [OPC_W-1:0] OP_HALT = 5'h1B;

    // T0..T7 must stay contiguous and directly after ST_RST: step_state()
    // relies on ST_Tn == n + 1.
    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7,
        ST_PAUSE, ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        CL_RALU, CL_UNARY, CL_IMM, CL_MULDIV, CL_LD, CL_LDI, CL_ST,
        CL_MF, CL_NOP, CL_HALT
    } instr_class_t;

    typedef struct packed {
        logic pc_out, zhigh_out, zlow_out, mdr_out, hi_out, lo_out;
        logic c_out, ba_out, r_out;
        logic mar_in, pc_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, r_in;
        logic gra, grb, grc;
        logic inc_pc, read, write;
        logic [OPC_W-1:0] op;
    } ctrl_t;

    function automatic state_t step_state(input logic [2:0] n);
        return state_t'({1'b0, n} + 4'd1);
    endfunction

    // Immediate forms reuse the register-form ALU operation.
    function automatic logic [OPC_W-1:0] imm_alu_op(input logic [OPC_W-1:0] opc);
        case (opc)
            OP_ANDI: return OP_AND;
            OP_ORI:  return OP_OR;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/instr_class_decode.sv
// instr_class_decode: combinational opcode classifier.
//   opcode    in   5  IR[31:27]
//   iclass    out     instruction class
//   last_step out  3  index n of the final execute step Tn (3..7)
module instr_class_decode
    import cpu_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output instr_class_t     iclass,
    output logic [2:0]       last_step
);

    always_comb begin
        // Reserved opcodes behave as nop: a single idle T3.
        iclass    = CL_NOP;
        last_step = 3'd3;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
                iclass    = CL_RALU;
                last_step = 3'd5;
            end
            OP_NEG, OP_NOT: begin
                iclass    = CL_UNARY;
                last_step = 3'd4;
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                iclass    = CL_IMM;
                last_step = 3'd5;
            end
            OP_MUL, OP_DIV: begin
                iclass    = CL_MULDIV;
                last_step = 3'd6;
            end
            OP_LD: begin
                iclass    = CL_LD;
                last_step = 3'd7;
            end
            OP_LDI: begin
                iclass    = CL_LDI;
                last_step = 3'd5;
            end
            OP_ST: begin
                iclass    = CL_ST;
                last_step = 3'd7;
            end
            OP_MFLO, OP_MFHI: begin
                iclass    = CL_MF;
                last_step = 3'd3;
            end
            OP_HALT: begin
                iclass    = CL_HALT;
                last_step = 3'd3;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the mini-CPU datapath.
//   Clock, clear (sync, active-high), stop (pause at instruction boundary),
//   IR (instruction from datapath).
//   run = 1 unless halted; bus-drive strobes (*out), register loads (*in),
//   register-field selects Gra/Grb/Grc, IncPC/Read/Write and ALU op.
// Strobes are a combinational decode of state and IR and are forced low
// while clear is high so a reset cycle never writes anything.
module control_unit
    import cpu_pkg::*;
#(
    parameter int OPW = 5,
    parameter int IRW = 32
) (
    input  logic           Clock,
    input  logic           clear,
    input  logic           stop,
    input  logic [IRW-1:0] IR,
    output logic           run,
    output logic           PCout,
    output logic           Zhighout,
    output logic           Zlowout,
    output logic           MDRout,
    output logic           HIout,
    output logic           LOout,
    output logic           Cout,
    output logic           BAout,
    output logic           Rout,
    output logic           MARin,
    output logic           PCin,
    output logic           MDRin,
    output logic           IRin,
    output logic           Yin,
    output logic           Zin,
    output logic           HIin,
    output logic           LOin,
    output logic           Rin,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           IncPC,
    output logic           Read,
    output logic           Write,
    output logic [OPW-1:0] op
);

    state_t           state_q, state_d;
    instr_class_t     iclass;
    logic [2:0]       last_step;
    logic [OPC_W-1:0] opc;
    ctrl_t            ctrl;
    logic             unused_ir;

    assign opc       = IR[IRW-1 -: OPC_W];
    assign unused_ir = ^IR[IRW-OPC_W-1:0];

    instr_class_decode u_decode (
        .opcode    (opc),
        .iclass    (iclass),
        .last_step (last_step)
    );

    always_ff @(posedge Clock) begin
        if (clear) state_q <= ST_RST;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST: state_d = ST_T0;
            ST_T0:  state_d = ST_T1;
            ST_T1:  state_d = ST_T2;
            ST_T2:  state_d = ST_T3;
            ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                // Only the final step of an instruction may divert to PAUSE/HALT.
                if (state_q == step_state(last_step)) begin
                    if (iclass == CL_HALT) state_d = ST_HALT;
                    else if (stop)         state_d = ST_PAUSE;
                    else                   state_d = ST_T0;
                end else begin
                    state_d = state_t'(state_q + 4'd1);
                end
            end
            ST_PAUSE: if (!stop) state_d = ST_T0;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RST;
        endcase
        if (clear) state_d = ST_RST;
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_T0: begin
                ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1;
            end
            ST_T1: begin
                ctrl.zlow_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
            end
            ST_T2: begin
                ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
            end
            ST_T3: begin
                case (iclass)
                    CL_RALU, CL_IMM: begin
                        ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
                    end
                    CL_UNARY: begin
                        ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.op = opc; ctrl.z_in = 1'b1;
                    end
                    CL_MULDIV: begin
                        ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
                    end
                    CL_LD, CL_LDI, CL_ST: begin
                        ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
                    end
                    CL_MF: begin
                        ctrl.hi_out = (opc == OP_MFHI);
                        ctrl.lo_out = (opc != OP_MFHI);
                        ctrl.gra    = 1'b1;
                        ctrl.r_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (iclass)
                    CL_RALU, CL_MULDIV: begin
                        ctrl.grc  = (iclass == CL_RALU);
                        ctrl.grb  = (iclass == CL_MULDIV);
                        ctrl.r_out = 1'b1; ctrl.op = opc; ctrl.z_in = 1'b1;
                    end
                    CL_UNARY: begin
                        ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    CL_IMM: begin
                        ctrl.c_out = 1'b1; ctrl.op = imm_alu_op(opc); ctrl.z_in = 1'b1;
                    end
                    CL_LD, CL_LDI, CL_ST: begin
                        ctrl.c_out = 1'b1; ctrl.op = OP_ADD; ctrl.z_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (iclass)
                    CL_RALU, CL_IMM, CL_LDI: begin
                        ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    CL_MULDIV: begin
                        ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (iclass)
                    CL_MULDIV: begin
                        ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1;
                    end
                    CL_LD: begin
                        ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
                    end
                    CL_ST: begin
                        ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                if (iclass == CL_LD) begin
                    ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                end else if (iclass == CL_ST) begin
                    ctrl.write = 1'b1;
                end
            end
            default: ;
        endcase
        if (clear) ctrl = '0;
    end

    assign run      = (state_q != ST_HALT);
    assign PCout    = ctrl.pc_out;
    assign Zhighout = ctrl.zhigh_out;
    assign Zlowout  = ctrl.zlow_out;
    assign MDRout   = ctrl.mdr_out;
    assign HIout    = ctrl.hi_out;
    assign LOout    = ctrl.lo_out;
    assign Cout     = ctrl.c_out;
    assign BAout    = ctrl.ba_out;
    assign Rout     = ctrl.r_out;
    assign MARin    = ctrl.mar_in;
    assign PCin     = ctrl.pc_in;
    assign MDRin    = ctrl.mdr_in;
    assign IRin     = ctrl.ir_in;
    assign Yin      = ctrl.y_in;
    assign Zin      = ctrl.z_in;
    assign HIin     = ctrl.hi_in;
    assign LOin     = ctrl.lo_in;
    assign Rin      = ctrl.r_in;
    assign Gra      = ctrl.gra;
    assign Grb      = ctrl.grb;
    assign Grc      = ctrl.grc;
    assign IncPC    = ctrl.inc_pc;
    assign Read     = ctrl.read;
    assign Write    = ctrl.write;
    assign op       = OPW'(ctrl.op);

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed scenarios followed by randomized instruction,
// stop and clear traffic, all checked cycle by cycle against a reference
// model that expands each instruction into its list of per-step strobe words.
module tb_control_unit;

    localparam int W = 29;

    logic        Clock = 1'b0;
    logic        clear = 1'b1;
    logic        stop  = 1'b0;
    logic [31:0] IR    = '0;
    logic        run;
    logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, BAout, Rout;
    logic        MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin;
    logic        Gra, Grb, Grc, IncPC, Read, Write;
    logic [4:0]  op;

    control_unit #(.OPW(5), .IRW(32)) dut (
        .Clock(Clock), .clear(clear), .stop(stop), .IR(IR), .run(run),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .Zin(Zin), .HIin(HIin), .LOin(LOin), .Rin(Rin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .Write(Write),
        .op(op)
    );

    // Clock / reset
    initial forever #5 Clock = ~Clock;

    logic [W-1:0] obs;
    assign obs = {op, Write, Read, IncPC, Grc, Grb, Gra, Rin, LOin, HIin, Zin, Yin,
                  IRin, MDRin, PCin, MARin, Rout, BAout, Cout, LOout, HIout,
                  MDRout, Zlowout, Zhighout, PCout};

    localparam logic [W-1:0] S_PCOUT    = W'(1) << 0;
    localparam logic [W-1:0] S_ZHIGHOUT = W'(1) << 1;
    localparam logic [W-1:0] S_ZLOWOUT  = W'(1) << 2;
    localparam logic [W-1:0] S_MDROUT   = W'(1) << 3;
    localparam logic [W-1:0] S_HIOUT    = W'(1) << 4;
    localparam logic [W-1:0] S_LOOUT    = W'(1) << 5;
    localparam logic [W-1:0] S_COUT     = W'(1) << 6;
    localparam logic [W-1:0] S_BAOUT    = W'(1) << 7;
    localparam logic [W-1:0] S_ROUT     = W'(1) << 8;
    localparam logic [W-1:0] S_MARIN    = W'(1) << 9;
    localparam logic [W-1:0] S_PCIN     = W'(1) << 10;
    localparam logic [W-1:0] S_MDRIN    = W'(1) << 11;
    localparam logic [W-1:0] S_IRIN     = W'(1) << 12;
    localparam logic [W-1:0] S_YIN      = W'(1) << 13;
    localparam logic [W-1:0] S_ZIN      = W'(1) << 14;
    localparam logic [W-1:0] S_HIIN     = W'(1) << 15;
    localparam logic [W-1:0] S_LOIN     = W'(1) << 16;
    localparam logic [W-1:0] S_RIN      = W'(1) << 17;
    localparam logic [W-1:0] S_GRA      = W'(1) << 18;
    localparam logic [W-1:0] S_GRB      = W'(1) << 19;
    localparam logic [W-1:0] S_GRC      = W'(1) << 20;
    localparam logic [W-1:0] S_INCPC    = W'(1) << 21;
    localparam logic [W-1:0] S_READ     = W'(1) << 22;
    localparam logic [W-1:0] S_WRITE    = W'(1) << 23;

    function automatic logic [W-1:0] alu(input int o);
        return W'(o) << 24;
    endfunction

    // Reference model
    typedef enum int {M_RST, M_RUN, M_PAUSE, M_HALT} mode_e;

    mode_e        mode  = M_RST;
    bit           known = 1'b0;
    logic [W-1:0] exp_q[$];       // strobe words of the current instruction, T0 first
    int           pos   = 0;
    logic [31:0]  cur_ir = '0;
    logic [31:0]  ir_plan[$];
    int           checks = 0;
    int           errors = 0;

    function automatic void load_instr();
        int o;
        if (ir_plan.size() > 0) begin
            cur_ir = ir_plan.pop_front();
        end else begin
            cur_ir = $urandom;
            if (cur_ir[31:27] == 5'h1B && $urandom_range(0, 3) != 0) cur_ir[31:27] = 5'h1A;
        end
        o = int'(cur_ir[31:27]);
        exp_q.delete();
        exp_q.push_back(S_PCOUT | S_MARIN | S_INCPC | S_ZIN);
        exp_q.push_back(S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN);
        exp_q.push_back(S_MDROUT | S_IRIN);
        if (o >= 3 && o <= 11) begin
            exp_q.push_back(S_GRB | S_ROUT | S_YIN);
            exp_q.push_back(S_GRC | S_ROUT | S_ZIN | alu(o));
            exp_q.push_back(S_ZLOWOUT | S_GRA | S_RIN);
        end else if (o == 17 || o == 18) begin
            exp_q.push_back(S_GRB | S_ROUT | S_ZIN | alu(o));
            exp_q.push_back(S_ZLOWOUT | S_GRA | S_RIN);
        end else if (o >= 12 && o <= 14) begin
            exp_q.push_back(S_GRB | S_ROUT | S_YIN);
            exp_q.push_back(S_COUT | S_ZIN | alu(o == 12 ? 3 : (o == 13 ? 5 : 6)));
            exp_q.push_back(S_ZLOWOUT | S_GRA | S_RIN);
        end else if (o == 15 || o == 16) begin
            exp_q.push_back(S_GRA | S_ROUT | S_YIN);
            exp_q.push_back(S_GRB | S_ROUT | S_ZIN | alu(o));
            exp_q.push_back(S_ZLOWOUT | S_LOIN);
            exp_q.push_back(S_ZHIGHOUT | S_HIIN);
        end else if (o <= 2) begin
            exp_q.push_back(S_GRB | S_BAOUT | S_YIN);
            exp_q.push_back(S_COUT | S_ZIN | alu(3));
            if (o == 1) begin
                exp_q.push_back(S_ZLOWOUT | S_GRA | S_RIN);
            end else begin
                exp_q.push_back(S_ZLOWOUT | S_MARIN);
                if (o == 0) begin
                    exp_q.push_back(S_READ | S_MDRIN);
                    exp_q.push_back(S_MDROUT | S_GRA | S_RIN);
                end else begin
                    exp_q.push_back(S_GRA | S_ROUT | S_MDRIN);
                    exp_q.push_back(S_WRITE);
                end
            end
        end else if (o == 24) begin
            exp_q.push_back(S_LOOUT | S_GRA | S_RIN);
        end else if (o == 25) begin
            exp_q.push_back(S_HIOUT | S_GRA | S_RIN);
        end else begin
            exp_q.push_back('0);
        end
        pos = 0;
    endfunction

    // Driver: one clock cycle with the given clear/stop, checked, then the model steps.
    task automatic cycle(input logic clr, input logic stp);
        logic [W-1:0] exp_c;
        logic         exp_run;
        @(negedge Clock);
        clear = clr;
        stop  = stp;
        // IR only carries the real instruction from T3; garbage before that.
        if (known && mode == M_RUN && pos >= 3) IR = cur_ir;
        else                                     IR = $urandom;
        #1;
        exp_c = '0;
        if (!clr && known && mode == M_RUN) exp_c = exp_q[pos];
        exp_run = (mode != M_HALT);
        checks++;
        assert (obs === exp_c) else begin
            errors++;
            $error("FAIL strobes mode=%0d pos=%0d ir=%h clear=%0b observed=%h expected=%h",
                   mode, pos, cur_ir, clr, obs, exp_c);
        end
        if (known) begin
            checks++;
            assert (run === exp_run) else begin
                errors++;
                $error("FAIL run mode=%0d pos=%0d observed=%0b expected=%0b",
                       mode, pos, run, exp_run);
            end
        end
        if (clr) begin
            mode  = M_RST;
            known = 1'b1;
        end else if (known) begin
            case (mode)
                M_RST: begin
                    mode = M_RUN;
                    load_instr();
                end
                M_RUN: begin
                    if (pos == exp_q.size() - 1) begin
                        if (cur_ir[31:27] == 5'h1B) mode = M_HALT;
                        else if (stp)               mode = M_PAUSE;
                        else                        load_instr();
                    end else begin
                        pos++;
                    end
                end
                M_PAUSE: begin
                    if (!stp) begin
                        mode = M_RUN;
                        load_instr();
                    end
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        ir_plan.push_back(32'h28918000);   // and R1,R2,R3
        ir_plan.push_back(32'h00900054);   // ld R1,0x54(R2)
        ir_plan.push_back(32'h81880000);   // mul R3,R1
        ir_plan.push_back(32'h10880000);   // st R1,0(R1)
        ir_plan.push_back(32'hD8000000);   // halt

        // Clear for two cycles (stop+clear together on the first), then RST, T0...
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);                 // RST

        // and: six cycles then T0 of ld
        repeat (6) cycle(1'b0, 1'b0);

        // ld: eight cycles
        repeat (8) cycle(1'b0, 1'b0);

        // mul: stop raised during T4 is held off until after T6
        repeat (4) cycle(1'b0, 1'b0);      // T0..T3
        repeat (3) cycle(1'b0, 1'b1);      // T4..T6
        repeat (3) cycle(1'b0, 1'b1);      // PAUSE held
        cycle(1'b0, 1'b0);                 // PAUSE, stop dropped -> T0 next

        // st: clear at T6 means Write never appears
        repeat (6) cycle(1'b0, 1'b0);      // T0..T5
        cycle(1'b1, 1'b0);                 // T6 with clear
        cycle(1'b0, 1'b0);                 // RST

        // halt: idle T3 then HALT through stop toggling, clear revives
        repeat (4) cycle(1'b0, 1'b0);
        repeat (20) cycle(1'b0, 1'($urandom_range(0, 1)));
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);                 // RST, run=1

        // Randomized traffic
        repeat (1500) begin
            logic clr_r, stp_r;
            if (mode == M_HALT) clr_r = ($urandom_range(0, 7) == 0);
            else                clr_r = ($urandom_range(0, 79) == 0);
            stp_r = ($urandom_range(0, 5) == 0);
            cycle(clr_r, stp_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
